// File: rtl/dmem_if.sv
// Bus bundle between the MEM stage, the data-memory port sequencer and the
// data memory. The sequencer itself uses the slave view; whatever drives the
// stage request and the memory response uses the master view.
interface dmem_if;
  // Stage request side
  logic        req_rw;
  logic        wr_en;
  logic        byte_op;
  logic [15:0] addr;
  logic [15:0] wdata;
  // Memory response side
  logic        mem_resp;
  logic [15:0] mem_rdata;
  // Held memory request
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  // Pipeline feedback
  logic        stall;
  logic [15:0] rdata;
  logic        rdata_valid;

  modport slave (
    input  req_rw, wr_en, byte_op, addr, wdata, mem_resp, mem_rdata,
    output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
    output stall, rdata, rdata_valid
  );

  modport master (
    output req_rw, wr_en, byte_op, addr, wdata, mem_resp, mem_rdata,
    input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
    input  stall, rdata, rdata_valid
  );
endinterface

// File: rtl/dmem_port.sv
// Data-memory port sequencer for the MEM stage. Accepts a one-cycle stage
// request, holds it on the memory bus until mem_resp, stalls the pipeline in
// the meantime, formats load data and counts stall cycles.
module dmem_port #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  dmem_if.slave            bus,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [15:0]      mem_address_q, mem_address_d;
  logic [1:0]       mem_byte_enable_q, mem_byte_enable_d;
  logic [15:0]      mem_wdata_q, mem_wdata_d;
  logic             lane_q, lane_d;      // latched addr[0], picks the load byte
  logic             byte_q, byte_d;      // latched byte_op, picks load format
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             stall;
  logic             byte_wr;
  logic             rdata_valid;
  logic [7:0]       load_byte;
  logic [15:0]      rdata;

  // Next-state and request-latch logic; mem_* only change on accept or on response.
  always_comb begin
    state_d           = state_q;
    mem_read_d        = mem_read_q;
    mem_write_d       = mem_write_q;
    mem_address_d     = mem_address_q;
    mem_byte_enable_d = mem_byte_enable_q;
    mem_wdata_d       = mem_wdata_q;
    lane_d            = lane_q;
    byte_d            = byte_q;
    byte_wr           = bus.wr_en & bus.byte_op;
    case (state_q)
      IDLE: begin
        if (bus.req_rw) begin
          state_d           = BUSY;
          mem_read_d        = ~bus.wr_en;
          mem_write_d       = bus.wr_en;
          mem_address_d     = {bus.addr[15:1], 1'b0};
          // Byte stores drive a single lane and replicate the byte on both halves
          mem_byte_enable_d = byte_wr ? (bus.addr[0] ? 2'b10 : 2'b01) : 2'b11;
          mem_wdata_d       = byte_wr ? {bus.wdata[7:0], bus.wdata[7:0]} : bus.wdata;
          lane_d            = bus.addr[0];
          byte_d            = bus.byte_op;
        end
      end
      BUSY: begin
        if (bus.mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is combinational so the stage freezes in its own request cycle.
  always_comb begin
    stall = ((state_q == IDLE) & bus.req_rw) | ((state_q == BUSY) & ~bus.mem_resp);
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Load formatting: byte loads pick the latched lane and sign-extend.
  always_comb begin
    rdata_valid = (state_q == BUSY) & bus.mem_resp & mem_read_q;
    load_byte   = lane_q ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
    rdata       = 16'h0000;
    if (rdata_valid) begin
      rdata = byte_q ? {{8{load_byte[7]}}, load_byte} : bus.mem_rdata;
    end
  end

  // State and held-request registers; reset wins over accept and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_address_q     <= 16'h0000;
      mem_byte_enable_q <= 2'b00;
      mem_wdata_q       <= 16'h0000;
      lane_q            <= 1'b0;
      byte_q            <= 1'b0;
      cnt_q             <= '0;
    end else begin
      state_q           <= state_d;
      mem_read_q        <= mem_read_d;
      mem_write_q       <= mem_write_d;
      mem_address_q     <= mem_address_d;
      mem_byte_enable_q <= mem_byte_enable_d;
      mem_wdata_q       <= mem_wdata_d;
      lane_q            <= lane_d;
      byte_q            <= byte_d;
      cnt_q             <= cnt_d;
    end
  end

  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_byte_enable = mem_byte_enable_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.stall           = stall;
  assign bus.rdata           = rdata;
  assign bus.rdata_valid     = rdata_valid;
  assign stall_cycles        = cnt_q;

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: directed test-plan scenarios plus
// randomized transactions checked against a transaction-level model.
module tb_dmem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] stall_cycles;
  logic [3:0]  stall_cycles_s;

  int pass_cnt  = 0;
  int chk_cnt   = 0;
  int txn_cnt   = 0;
  int model_stall = 0;   // expected stall-edge count since last reset

  dmem_if bus();
  dmem_if bus_s();

  dmem_port #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_cycles(stall_cycles)
  );

  dmem_port #(.CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .bus(bus_s), .stall_cycles(stall_cycles_s)
  );

  always #5 clk = ~clk;

  // Reference expectations computed from the access description alone
  function automatic logic [15:0] ref_addr(input logic [15:0] a);
    return a - (a % 2);
  endfunction

  function automatic logic [1:0] ref_be(input logic rw, bt, input logic [15:0] a);
    if (rw && bt) return (a % 2 == 1) ? 2'd2 : 2'd1;
    return 2'd3;
  endfunction

  function automatic logic [15:0] ref_wdata(input logic rw, bt, input logic [15:0] wd);
    if (rw && bt) return (wd % 256) * 257;
    return wd;
  endfunction

  function automatic logic [15:0] ref_rdata(input logic bt, input logic [15:0] a, md);
    int b;
    if (!bt) return md;
    b = (a % 2 == 1) ? (md / 256) : (md % 256);
    if (b >= 128) b = b + 32'hFF00;
    return 16'(b);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full access: accept cycle, waitn wait cycles, response cycle.
  task automatic do_txn(input logic rw, input logic bt, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] md,
                        input int waitn, input string name);
    logic [15:0] e_addr, e_wd, e_rd, e_rdv;
    logic [1:0]  e_be;
    logic [35:0] got_bus, exp_bus;
    e_addr = ref_addr(a);
    e_be   = ref_be(rw, bt, a);
    e_wd   = ref_wdata(rw, bt, wd);
    e_rd   = ref_rdata(bt, a, md);
    bus.req_rw = 1'b1; bus.wr_en = rw; bus.byte_op = bt;
    bus.addr = a; bus.wdata = wd;
    bus.mem_resp = 1'b0; bus.mem_rdata = 16'($urandom);
    @(negedge clk);
    chk_cnt++;
    if (bus.stall !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0)
      $display("FAIL %s accept: stall/rd/wr got %b%b%b want 100", name,
               bus.stall, bus.mem_read, bus.mem_write);
    else pass_cnt++;
    step();
    model_stall++;
    for (int w = 0; w <= waitn; w++) begin
      // Request inputs are scrambled while busy; they must be ignored
      bus.req_rw = 1'($urandom); bus.wr_en = 1'($urandom);
      bus.byte_op = 1'($urandom); bus.addr = 16'($urandom);
      bus.wdata = 16'($urandom);
      bus.mem_resp = (w == waitn);
      bus.mem_rdata = (w == waitn) ? md : 16'($urandom);
      @(negedge clk);
      got_bus = {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_byte_enable, bus.mem_wdata};
      exp_bus = {~rw, rw, e_addr, e_be, e_wd};
      chk_cnt++;
      if (got_bus !== exp_bus)
        $display("FAIL %s bus w%0d: got %h want %h", name, w, got_bus, exp_bus);
      else pass_cnt++;
      chk_cnt++;
      if (bus.stall !== (w != waitn))
        $display("FAIL %s stall w%0d: got %b want %b", name, w, bus.stall, (w != waitn));
      else pass_cnt++;
      e_rdv = (w == waitn && !rw) ? e_rd : 16'h0000;
      chk_cnt++;
      if (bus.rdata_valid !== (w == waitn && !rw) || bus.rdata !== e_rdv)
        $display("FAIL %s rdata w%0d: got v=%b %h want v=%b %h", name, w,
                 bus.rdata_valid, bus.rdata, (w == waitn && !rw), e_rdv);
      else pass_cnt++;
      step();
      if (w != waitn) model_stall++;
    end
    bus.req_rw = 1'b0; bus.mem_resp = 1'b0;
    chk_cnt++;
    if (stall_cycles !== 16'(model_stall))
      $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cycles, model_stall);
    else pass_cnt++;
    txn_cnt++;
    $display("txn %0d %s: %s %s addr=%h wdata=%h rdata=%h wait=%0d", txn_cnt, name,
             rw ? "WR" : "RD", bt ? "byte" : "word", a, wd, e_rd, waitn);
  endtask

  // Quiet cycle: bus must be idle and an unsolicited mem_resp ignored.
  task automatic idle_cycle(input string name);
    bus.req_rw = 1'b0;
    bus.mem_resp = 1'($urandom);
    bus.mem_rdata = 16'($urandom);
    @(negedge clk);
    chk_cnt++;
    if ({bus.mem_read, bus.mem_write, bus.stall, bus.rdata_valid} !== 4'b0000 || bus.rdata !== 16'h0)
      $display("FAIL %s idle: rd/wr/stall/valid got %b%b%b%b rdata %h want 0000 0000", name,
               bus.mem_read, bus.mem_write, bus.stall, bus.rdata_valid, bus.rdata);
    else pass_cnt++;
    step();
    bus.mem_resp = 1'b0;
  endtask

  task automatic pulse_reset();
    bus.req_rw = 1'b0; bus.mem_resp = 1'b0;
    bus_s.req_rw = 1'b0; bus_s.mem_resp = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_stall = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_rw = 1'b1; bus.wr_en = 1'b1; bus.byte_op = 1'b0;
    bus.addr = 16'h1234; bus.wdata = 16'h5678;
    bus.mem_resp = 1'b1; bus.mem_rdata = 16'hAAAA;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      bus.req_rw = 1'(i);
      @(negedge clk);
      chk_cnt++;
      if ({bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_byte_enable, bus.mem_wdata} !== 36'h0)
        $display("FAIL reset bus: got %b %b %h %b %h want all zero", bus.mem_read, bus.mem_write,
                 bus.mem_address, bus.mem_byte_enable, bus.mem_wdata);
      else pass_cnt++;
      chk_cnt++;
      if (bus.rdata_valid !== 1'b0 || bus.rdata !== 16'h0 || stall_cycles !== 16'h0 || stall_cycles_s !== 4'h0)
        $display("FAIL reset out: valid %b rdata %h cnt %0d cnt_s %0d want 0 0 0 0",
                 bus.rdata_valid, bus.rdata, stall_cycles, stall_cycles_s);
      else pass_cnt++;
      chk_cnt++;
      if (bus.stall !== 1'(i))
        $display("FAIL reset stall: got %b want %b", bus.stall, 1'(i));
      else pass_cnt++;
      step();
    end
    pulse_reset();
    $display("txn reset: outputs checked under reset");
  endtask

  task automatic test_word_load();
    do_txn(1'b0, 1'b0, 16'h3005, 16'h0000, 16'hBEEF, 0, "word_load");
    idle_cycle("word_load");
  endtask

  task automatic test_byte_load();
    do_txn(1'b0, 1'b1, 16'h2001, 16'h0000, 16'h80FF, 0, "byte_load_hi");
    idle_cycle("byte_load_hi");
    do_txn(1'b0, 1'b1, 16'h2000, 16'h0000, 16'h80FF, 0, "byte_load_lo");
    idle_cycle("byte_load_lo");
    do_txn(1'b0, 1'b1, 16'h2001, 16'h0000, 16'h7F12, 0, "byte_load_pos");
    idle_cycle("byte_load_pos");
  endtask

  task automatic test_byte_store();
    do_txn(1'b1, 1'b1, 16'h4003, 16'h12AB, 16'h0000, 0, "byte_store");
    idle_cycle("byte_store");
  endtask

  task automatic test_slow_memory();
    pulse_reset();
    do_txn(1'b0, 1'b0, 16'(16'h5000 + $urandom_range(0, 255)), 16'h0, 16'($urandom), 4, "slow_mem");
    chk_cnt++;
    if (stall_cycles !== 16'd5)
      $display("FAIL slow_mem total stall: got %0d want 5", stall_cycles);
    else pass_cnt++;
    idle_cycle("slow_mem");
  endtask

  task automatic test_reset_mid_access();
    bus.req_rw = 1'b1; bus.wr_en = 1'b0; bus.byte_op = 1'b0;
    bus.addr = 16'h6006; bus.mem_resp = 1'b0;
    step();                 // accepted, now busy (cycle 1)
    bus.req_rw = 1'b0;
    step();                 // cycle 2 of busy
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_stall = 0;
    @(negedge clk);
    chk_cnt++;
    if (bus.mem_read !== 1'b0 || bus.mem_address !== 16'h0 || bus.stall !== 1'b0)
      $display("FAIL rst_mid: rd %b addr %h stall %b want 0 0000 0",
               bus.mem_read, bus.mem_address, bus.stall);
    else pass_cnt++;
    step();
    bus.mem_resp = 1'b1; bus.mem_rdata = 16'h1357;
    @(negedge clk);
    chk_cnt++;
    if (bus.rdata_valid !== 1'b0 || bus.stall !== 1'b0 || bus.rdata !== 16'h0)
      $display("FAIL rst_mid late resp: valid %b stall %b rdata %h want 0 0 0000",
               bus.rdata_valid, bus.stall, bus.rdata);
    else pass_cnt++;
    step();
    bus.mem_resp = 1'b0;
    chk_cnt++;
    if (stall_cycles !== 16'd0)
      $display("FAIL rst_mid counter: got %0d want 0", stall_cycles);
    else pass_cnt++;
    $display("txn reset_mid: busy read aborted, late response ignored");
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 1'b0, 16'h7000, 16'hCAFE, 16'h0, 0, "b2b_0");
    do_txn(1'b0, 1'b1, 16'h7001, 16'h0, 16'hA55A, 1, "b2b_1");
    do_txn(1'b0, 1'b0, 16'h7002, 16'h0, 16'h0F0F, 0, "b2b_2");
    idle_cycle("b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 3), "random");
      if ($urandom_range(0, 1) == 1) idle_cycle("random");
    end
    idle_cycle("random_end");
  endtask

  task automatic test_counter_sat();
    pulse_reset();
    bus_s.req_rw = 1'b1; bus_s.wr_en = 1'b0; bus_s.byte_op = 1'b0;
    bus_s.addr = 16'h0100; bus_s.wdata = 16'h0; bus_s.mem_resp = 1'b0;
    bus_s.mem_rdata = 16'h0;
    for (int i = 1; i <= 20; i++) begin
      step();
      bus_s.req_rw = 1'($urandom);
      chk_cnt++;
      if (stall_cycles_s !== 4'((i > 15) ? 15 : i))
        $display("FAIL counter_sat cycle %0d: got %0d want %0d", i, stall_cycles_s,
                 (i > 15) ? 15 : i);
      else pass_cnt++;
    end
    bus_s.req_rw = 1'b0;
    $display("txn counter_sat: 20 stall cycles, counter %0d", stall_cycles_s);
  endtask

  initial begin
    bus.req_rw = 1'b0; bus.wr_en = 1'b0; bus.byte_op = 1'b0;
    bus.addr = 16'h0; bus.wdata = 16'h0; bus.mem_resp = 1'b0; bus.mem_rdata = 16'h0;
    bus_s.req_rw = 1'b0; bus_s.wr_en = 1'b0; bus_s.byte_op = 1'b0;
    bus_s.addr = 16'h0; bus_s.wdata = 16'h0; bus_s.mem_resp = 1'b0; bus_s.mem_rdata = 16'h0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_byte_store();
    test_slow_memory();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    test_counter_sat();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
